minisrc_datapath: RTL and testbench
===================================

// Module: minisrc_datapath
// PURPOSE
//  32-bit MiniSRC processor datapath: PC, 16x32 register file, ALU operand regs (RA/RB),
//  64-bit result regs (RZH/RZL), storage reg RAS, write-back reg RWB, memory address/data
//  muxes. Purely control-driven: every enable/select comes from the external control unit.
// PARAMETERS
//  none (data width fixed at 32, 16 registers)
// PORTS
//  iClk in 1 clock, all state updates on rising edge; nRst in 1 async active-low reset
//  iMemData in 32 memory read data | oMemAddr out 32 memory address | oMemData out 32 store data
//  iPC_nRst in 1 sync PC clear (active low) | iPC_en in 1 PC update | iPC_jmp in 1 jump taken
//  iPC_loadRA in 1 PC<=RA | iPC_loadImm in 1 PC-relative jump
//  iRF_Write in 1 RF write | iRF_AddrA/iRF_AddrB/iRF_AddrC in 4 read A/read B/write index
//  iRWB_en in 1 RWB load | iALU_Ctrl in 4 ALU op | iRA_en,iRB_en,iRZH_en,iRZL_en,iRAS_en in 1 reg loads
//  oJ_zero,oJ_nZero,oJ_pos,oJ_neg out 1 branch flags | oALU_neg,oALU_zero out 1 RZL flags
//  iMUX_BIS in 1 RB src imm | iMUX_RZHS in 1 Z hi sel | iMUX_WBM in 1 WB<=mem | iMUX_WBP in 1 WB<=PC
//  iMUX_MAP in 1 addr<=PC | iMUX_ASS in 1 WB<=RAS | iImm32 in 32 sign-extended immediate
// BEHAVIOUR
//  - nRst low (async): PC, RF[0..15], RA, RB, RZH, RZL, RAS, RWB all 0.
//  - RF: read ports A/B combinational; write RF[iRF_AddrC]<=RWB on edge when iRF_Write.
//    Read of register written same edge returns old value. All 16 regs writable.
//  - RA<=RF[A] if iRA_en; RB<=(iMUX_BIS?iImm32:RF[B]) if iRB_en. One-cycle latency.
//  - ALU combinational on RA,RB -> 64-bit {hi,lo}; hi=0 except MUL/DIV.
//    Codes: 0 ADD,1 SUB,2 AND,3 OR,4 SHR,5 SRA,6 SHL,7 ROR,8 ROL,9 MUL(signed 64b),
//    A DIV (lo=quot,hi=rem, signed),B NEG(-RA),C NOT(~RA),D PASSA,E PASSB,F ->0.
//    Shifts/rotates use RB[4:0] only. DIV by 0: lo=32'hFFFFFFFF, hi=RA. Add/sub wrap mod 2^32.
//  - RZH<=hi if iRZH_en; RZL<=lo if iRZL_en (independent).
//  - RAS<=(iMUX_RZHS?RZH:RZL) if iRAS_en.
//  - RWB load source priority: iMUX_WBM iMemData > iMUX_WBP PC > iMUX_ASS RAS > (iMUX_RZHS?RZH:RZL).
//  - PC: iPC_nRst=0 -> PC<=0 (overrides en). Else if iPC_en: iPC_loadRA -> PC<=RA;
//    else iPC_jmp&iPC_loadImm -> PC<=PC+1+iImm32; else PC<=PC+1. Wraps mod 2^32.
//  - oMemAddr = iMUX_MAP ? PC : RZL; oMemData = RF[iRF_AddrB] (combinational).
//  - oALU_zero=(RZL==0); oALU_neg=RZL[31].
//  - Branch flags from RA: zero=(RA==0); nZero=~zero; neg=RA[31]; pos=~RA[31]&~zero.
//  - Simultaneous loads in one edge all use pre-edge values (e.g. RWB and RF write same edge:
//    RF gets old RWB).
// STRUCTURE
//  - ALU op codes (CTRL_ALU_*) in shared ALU header; instruction encodings in shared ISA header.
//  - Sub-module alu (combinational, 64-bit result); RF and regs inline.
// TESTING
//  - Load via RWB: iMemData=0x80000022,WBM=1,RWB_en; then RF_Write,AddrC=3 -> RF[3]=0x80000022.
//  - SRA: R3=0x80000022,R7=0x24; RA<-R3,RB<-R7, op 5, RZL->RWB->R4 -> R4=0xF8000002, neg=1.
//  - MUL: RA=0xFFFFFFFE,RB=3 -> RZH=0xFFFFFFFF,RZL=0xFFFFFFFA; DIV 7/0 -> RZL=0xFFFFFFFF,RZH=7.
//  - PC: PC_nRst=1,en=1 thrice -> PC=3, oMemAddr=3 with MAP=1; jmp+loadImm imm=-2 -> PC=2.
//  - Imm: BIS=1,iImm32=5, RA=10, ADD -> RZL=15; SUB 10-15 -> 0xFFFFFFFB, oALU_neg=1.
//  - Assert nRst low mid-sequence -> all regs/PC read 0 immediately, flags zero=1,nZero=0.

Source files
------------

// File: rtl/minisrc_pkg.sv
// Shared MiniSRC definitions: ALU operation codes, datapath sizes and instruction opcodes.
package minisrc_pkg;
    localparam int DW   = 32;
    localparam int NREG = 16;
    localparam int RW   = $clog2(NREG);

    typedef enum logic [3:0] {
        CTRL_ALU_ADD   = 4'h0,
        CTRL_ALU_SUB   = 4'h1,
        CTRL_ALU_AND   = 4'h2,
        CTRL_ALU_OR    = 4'h3,
        CTRL_ALU_SHR   = 4'h4,
        CTRL_ALU_SRA   = 4'h5,
        CTRL_ALU_SHL   = 4'h6,
        CTRL_ALU_ROR   = 4'h7,
        CTRL_ALU_ROL   = 4'h8,
        CTRL_ALU_MUL   = 4'h9,
        CTRL_ALU_DIV   = 4'hA,
        CTRL_ALU_NEG   = 4'hB,
        CTRL_ALU_NOT   = 4'hC,
        CTRL_ALU_PASSA = 4'hD,
        CTRL_ALU_PASSB = 4'hE,
        CTRL_ALU_ZERO  = 4'hF
    } alu_op_e;

    // Instruction opcode field (bits 31:27); decoded by the control unit, not here.
    typedef enum logic [4:0] {
        OP_LD   = 5'h00, OP_LDI  = 5'h01, OP_ST   = 5'h02,
        OP_ADD  = 5'h03, OP_SUB  = 5'h04, OP_AND  = 5'h05,
        OP_OR   = 5'h06, OP_SHR  = 5'h07, OP_SHRA = 5'h08,
        OP_SHL  = 5'h09, OP_ROR  = 5'h0A, OP_ROL  = 5'h0B,
        OP_ADDI = 5'h0C, OP_ANDI = 5'h0D, OP_ORI  = 5'h0E,
        OP_MUL  = 5'h0F, OP_DIV  = 5'h10, OP_NEG  = 5'h11,
        OP_NOT  = 5'h12, OP_BR   = 5'h13, OP_JR   = 5'h14,
        OP_JAL  = 5'h15, OP_IN   = 5'h16, OP_OUT  = 5'h17,
        OP_MFHI = 5'h18, OP_MFLO = 5'h19, OP_NOP  = 5'h1A,
        OP_HALT = 5'h1B
    } opcode_e;
endpackage

// File: rtl/minisrc_datapath_alu.sv
// Combinational MiniSRC ALU producing a 64-bit {hi, lo}; hi is only non-zero for MUL/DIV.
module minisrc_datapath_alu
    import minisrc_pkg::*;
(
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [3:0]      op,
    output logic [2*DW-1:0] res
);
    logic [4:0]          sh;
    logic [5:0]          rsh;
    logic signed [DW-1:0] sa, sb;
    logic signed [2*DW-1:0] prod;

    assign sh   = b[4:0];
    assign rsh  = 6'd32 - {1'b0, sh};
    assign sa   = $signed(a);
    assign sb   = $signed(b);
    assign prod = (2*DW)'(sa) * (2*DW)'(sb);

    always_comb begin
        res = '0;
        case (alu_op_e'(op))
            CTRL_ALU_ADD:   res[DW-1:0] = a + b;
            CTRL_ALU_SUB:   res[DW-1:0] = a - b;
            CTRL_ALU_AND:   res[DW-1:0] = a & b;
            CTRL_ALU_OR:    res[DW-1:0] = a | b;
            CTRL_ALU_SHR:   res[DW-1:0] = a >> sh;
            CTRL_ALU_SRA:   res[DW-1:0] = sa >>> sh;
            CTRL_ALU_SHL:   res[DW-1:0] = a << sh;
            // A shift by 32 clears the 32-bit term, so sh==0 rotates to a unchanged.
            CTRL_ALU_ROR:   res[DW-1:0] = (a >> sh) | (a << rsh);
            CTRL_ALU_ROL:   res[DW-1:0] = (a << sh) | (a >> rsh);
            CTRL_ALU_MUL:   res = prod;
            CTRL_ALU_DIV: begin
                if (b == '0)
                    res = {a, {DW{1'b1}}};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {{DW{1'b0}}, a};   // overflowing quotient pinned to INT_MIN
                else
                    res = {DW'(sa % sb), DW'(sa / sb)};
            end
            CTRL_ALU_NEG:   res[DW-1:0] = -a;
            CTRL_ALU_NOT:   res[DW-1:0] = ~a;
            CTRL_ALU_PASSA: res[DW-1:0] = a;
            CTRL_ALU_PASSB: res[DW-1:0] = b;
            default:        res = '0;
        endcase
    end
endmodule

// File: rtl/minisrc_datapath.sv
// MiniSRC datapath: PC, 16x32 register file, RA/RB/RZH/RZL/RAS/RWB and memory muxes,
// all steered by an external control unit.
module minisrc_datapath
    import minisrc_pkg::*;
(
    input  logic          iClk,
    input  logic          nRst,
    input  logic [DW-1:0] iMemData,
    output logic [DW-1:0] oMemAddr,
    output logic [DW-1:0] oMemData,
    input  logic          iPC_nRst,
    input  logic          iPC_en,
    input  logic          iPC_jmp,
    input  logic          iPC_loadRA,
    input  logic          iPC_loadImm,
    input  logic          iRF_Write,
    input  logic [RW-1:0] iRF_AddrA,
    input  logic [RW-1:0] iRF_AddrB,
    input  logic [RW-1:0] iRF_AddrC,
    input  logic          iRWB_en,
    input  logic [3:0]    iALU_Ctrl,
    input  logic          iRA_en,
    input  logic          iRB_en,
    input  logic          iRZH_en,
    input  logic          iRZL_en,
    input  logic          iRAS_en,
    output logic          oJ_zero,
    output logic          oJ_nZero,
    output logic          oJ_pos,
    output logic          oJ_neg,
    output logic          oALU_neg,
    output logic          oALU_zero,
    input  logic          iMUX_BIS,
    input  logic          iMUX_RZHS,
    input  logic          iMUX_WBM,
    input  logic          iMUX_WBP,
    input  logic          iMUX_MAP,
    input  logic          iMUX_ASS,
    input  logic [DW-1:0] iImm32
);
    logic [DW-1:0]   rf [NREG];
    logic [DW-1:0]   pc, ra, rb, rzh, rzl, ras, rwb;
    logic [DW-1:0]   rf_a, rf_b, rz_sel, wb_next;
    logic [2*DW-1:0] alu_res;

    assign rf_a   = rf[iRF_AddrA];
    assign rf_b   = rf[iRF_AddrB];
    assign rz_sel = iMUX_RZHS ? rzh : rzl;

    always_comb begin
        wb_next = rz_sel;
        if (iMUX_WBM)      wb_next = iMemData;
        else if (iMUX_WBP) wb_next = pc;
        else if (iMUX_ASS) wb_next = ras;
    end

    minisrc_datapath_alu u_alu (
        .a   (ra),
        .b   (rb),
        .op  (iALU_Ctrl),
        .res (alu_res)
    );

    // All loads sample pre-edge values, so RF writes take the old RWB and reads see old RF.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            pc  <= '0;
            ra  <= '0;
            rb  <= '0;
            rzh <= '0;
            rzl <= '0;
            ras <= '0;
            rwb <= '0;
        end else begin
            if (iRF_Write) rf[iRF_AddrC] <= rwb;
            if (iRA_en)    ra  <= rf_a;
            if (iRB_en)    rb  <= iMUX_BIS ? iImm32 : rf_b;
            if (iRZH_en)   rzh <= alu_res[2*DW-1:DW];
            if (iRZL_en)   rzl <= alu_res[DW-1:0];
            if (iRAS_en)   ras <= rz_sel;
            if (iRWB_en)   rwb <= wb_next;
            if (!iPC_nRst)
                pc <= '0;
            else if (iPC_en) begin
                if (iPC_loadRA)                pc <= ra;
                else if (iPC_jmp && iPC_loadImm) pc <= pc + 32'd1 + iImm32;
                else                           pc <= pc + 32'd1;
            end
        end
    end

    assign oMemAddr  = iMUX_MAP ? pc : rzl;
    assign oMemData  = rf_b;
    assign oALU_zero = (rzl == '0);
    assign oALU_neg  = rzl[DW-1];
    assign oJ_zero   = (ra == '0);
    assign oJ_nZero  = ~oJ_zero;
    assign oJ_neg    = ra[DW-1];
    assign oJ_pos    = ~ra[DW-1] & ~oJ_zero;
endmodule

// File: tb/tb_minisrc_datapath.sv
// Self-checking bench for minisrc_datapath: expected values queued as stimulus is driven,
// popped and compared once the datapath output is observable.
module tb_minisrc_datapath;
    logic        iClk = 0, nRst = 0;
    logic [31:0] iMemData, oMemAddr, oMemData, iImm32;
    logic        iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm, iRF_Write;
    logic [3:0]  iRF_AddrA, iRF_AddrB, iRF_AddrC, iALU_Ctrl;
    logic        iRWB_en, iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en;
    logic        oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_neg, oALU_zero;
    logic        iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS;

    int checks = 0, errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v, got;

    always #5 iClk = ~iClk;

    minisrc_datapath dut (
        .iClk(iClk), .nRst(nRst), .iMemData(iMemData), .oMemAddr(oMemAddr), .oMemData(oMemData),
        .iPC_nRst(iPC_nRst), .iPC_en(iPC_en), .iPC_jmp(iPC_jmp), .iPC_loadRA(iPC_loadRA),
        .iPC_loadImm(iPC_loadImm), .iRF_Write(iRF_Write), .iRF_AddrA(iRF_AddrA),
        .iRF_AddrB(iRF_AddrB), .iRF_AddrC(iRF_AddrC), .iRWB_en(iRWB_en), .iALU_Ctrl(iALU_Ctrl),
        .iRA_en(iRA_en), .iRB_en(iRB_en), .iRZH_en(iRZH_en), .iRZL_en(iRZL_en), .iRAS_en(iRAS_en),
        .oJ_zero(oJ_zero), .oJ_nZero(oJ_nZero), .oJ_pos(oJ_pos), .oJ_neg(oJ_neg),
        .oALU_neg(oALU_neg), .oALU_zero(oALU_zero), .iMUX_BIS(iMUX_BIS), .iMUX_RZHS(iMUX_RZHS),
        .iMUX_WBM(iMUX_WBM), .iMUX_WBP(iMUX_WBP), .iMUX_MAP(iMUX_MAP), .iMUX_ASS(iMUX_ASS),
        .iImm32(iImm32)
    );

    task automatic idle();
        iMemData = 0; iImm32 = 0; iPC_nRst = 1; iPC_en = 0; iPC_jmp = 0; iPC_loadRA = 0;
        iPC_loadImm = 0; iRF_Write = 0; iRF_AddrA = 0; iRF_AddrB = 0; iRF_AddrC = 0;
        iRWB_en = 0; iALU_Ctrl = 0; iRA_en = 0; iRB_en = 0; iRZH_en = 0; iRZL_en = 0;
        iRAS_en = 0; iMUX_BIS = 0; iMUX_RZHS = 0; iMUX_WBM = 0; iMUX_WBP = 0; iMUX_MAP = 0;
        iMUX_ASS = 0;
    endtask

    task automatic tick();
        @(posedge iClk); #1;
        idle();
    endtask

    task automatic load_rf(input logic [3:0] r, input logic [31:0] v);
        iMemData = v; iMUX_WBM = 1; iRWB_en = 1; tick();
        iRF_Write = 1; iRF_AddrC = r; tick();
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] code,
                         input logic bis, input logic [31:0] imm);
        iRF_AddrA = a; iRF_AddrB = b; iRA_en = 1; iRB_en = 1; iMUX_BIS = bis; iImm32 = imm;
        tick();
        iALU_Ctrl = code; iRZH_en = 1; iRZL_en = 1; tick();
    endtask

    // Move RZL (hi=0) or RZH (hi=1) through RWB into RF[r].
    task automatic rz_to_rf(input logic hi, input logic [3:0] r);
        iMUX_RZHS = hi; iRWB_en = 1; tick();
        iRF_Write = 1; iRF_AddrC = r; tick();
    endtask

    task automatic read_rf(input logic [3:0] r, output logic [31:0] v);
        iRF_AddrB = r; #1; v = oMemData; iRF_AddrB = 0;
    endtask

    task automatic test_reset();
        nRst = 0; idle(); #2;
        for (int i = 0; i < 3; i++) sb_q.push_back(32'h0);
        read_rf(4'd5, got); exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_rf got=%h exp=%h", got, exp_v); end
        iMUX_MAP = 1; #1; got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_pc got=%h exp=%h", got, exp_v); end
        iMUX_MAP = 0; #1; got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_rzl got=%h exp=%h", got, exp_v); end
        checks++;
        if ({oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_zero, oALU_neg} !== 6'b10_0010) begin
            errors++; $display("FAIL reset_flags got=%b exp=100010",
                {oJ_zero, oJ_nZero, oJ_pos, oJ_neg, oALU_zero, oALU_neg});
        end
        @(negedge iClk); nRst = 1; tick();
    endtask

    task automatic test_load();
        sb_q.push_back(32'h8000_0022);
        load_rf(4'd3, 32'h8000_0022);
        read_rf(4'd3, got); exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL load_r3 got=%h exp=%h", got, exp_v); end
        // Same-edge RF write and RA read of R3: RA must see the old value.
        iMemData = 32'h0; iMUX_WBM = 1; iRWB_en = 1; tick();
        iRF_Write = 1; iRF_AddrC = 4'd3; iRF_AddrA = 4'd3; iRA_en = 1; tick();
        checks++;
        if (oJ_neg !== 1'b1) begin errors++; $display("FAIL rf_old_read neg=%b exp=1", oJ_neg); end
        sb_q.push_back(32'h0);
        read_rf(4'd3, got); exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL rf_overwrite got=%h exp=%h", got, exp_v); end
        // Same-edge RWB load and RF write: RF takes the old RWB.
        iMemData = 32'hAAAA_0001; iMUX_WBM = 1; iRWB_en = 1; tick();
        sb_q.push_back(32'hAAAA_0001);
        iMemData = 32'hBBBB_0002; iMUX_WBM = 1; iRWB_en = 1; iRF_Write = 1; iRF_AddrC = 4'd15;
        tick();
        read_rf(4'd15, got); exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL rwb_old got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_sra();
        load_rf(4'd3, 32'h8000_0022);
        load_rf(4'd7, 32'h0000_0024);
        sb_q.push_back(32'hF800_0002);
        do_op(4'd3, 4'd7, 4'h5, 0, 0);
        rz_to_rf(0, 4'd4);
        read_rf(4'd4, got); exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL sra_r4 got=%h exp=%h", got, exp_v); end
        checks++;
        if (oALU_neg !== 1'b1 || oALU_zero !== 1'b0) begin
            errors++; $display("FAIL sra_flags neg=%b zero=%b exp=1 0", oALU_neg, oALU_zero);
        end
    endtask

    task automatic test_muldiv();
        load_rf(4'd1, 32'hFFFF_FFFE);
        load_rf(4'd2, 32'h0000_0003);
        sb_q.push_back(32'hFFFF_FFFA); sb_q.push_back(32'hFFFF_FFFF);
        do_op(4'd1, 4'd2, 4'h9, 0, 0);
        got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL mul_lo got=%h exp=%h", got, exp_v); end
        // RZH via RAS and the RAS write-back path.
        iMUX_RZHS = 1; iRAS_en = 1; tick();
        iMUX_ASS = 1; iRWB_en = 1; tick();
        iRF_Write = 1; iRF_AddrC = 4'd5; tick();
        read_rf(4'd5, got); exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL mul_hi got=%h exp=%h", got, exp_v); end
        // Divide table: {a, b, quotient, remainder}
        begin
            logic [31:0] dt [3][4];
            dt[0] = '{32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7};
            dt[1] = '{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
            dt[2] = '{32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
            for (int i = 0; i < 3; i++) begin
                load_rf(4'd1, dt[i][0]); load_rf(4'd2, dt[i][1]);
                sb_q.push_back(dt[i][2]); sb_q.push_back(dt[i][3]);
                do_op(4'd1, 4'd2, 4'hA, 0, 0);
                got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
                if (got !== exp_v) begin errors++; $display("FAIL div_q%0d got=%h exp=%h", i, got, exp_v); end
                rz_to_rf(1, 4'd6);
                read_rf(4'd6, got); exp_v = sb_q.pop_front(); checks++;
                if (got !== exp_v) begin errors++; $display("FAIL div_r%0d got=%h exp=%h", i, got, exp_v); end
            end
        end
    endtask

    task automatic test_alu_ops();
        // {op, a, b, expected lo}
        logic [31:0] t [13][4];
        t[0]  = '{32'h0, 32'hFFFF_FFFF, 32'h1,         32'h0};
        t[1]  = '{32'h1, 32'h0,         32'h1,         32'hFFFF_FFFF};
        t[2]  = '{32'h2, 32'hF0F0_000F, 32'h0FF0_FF01, 32'h00F0_0001};
        t[3]  = '{32'h3, 32'hF0F0_000F, 32'h0FF0_FF01, 32'hFFF0_FF0F};
        t[4]  = '{32'h4, 32'h8000_0000, 32'h24,        32'h0800_0000};
        t[5]  = '{32'h6, 32'h1,         32'h1F,        32'h8000_0000};
        t[6]  = '{32'h7, 32'h1,         32'h1,         32'h8000_0000};
        t[7]  = '{32'h8, 32'h8000_0001, 32'h4,         32'h0000_0018};
        t[8]  = '{32'hB, 32'h5,         32'h0,         32'hFFFF_FFFB};
        t[9]  = '{32'hC, 32'h0,         32'h0,         32'hFFFF_FFFF};
        t[10] = '{32'hD, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678};
        t[11] = '{32'hE, 32'h1234_5678, 32'h9ABC_DEF0, 32'h9ABC_DEF0};
        t[12] = '{32'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        for (int i = 0; i < 13; i++) begin
            load_rf(4'd8, t[i][1]); load_rf(4'd9, t[i][2]);
            sb_q.push_back(t[i][3]);
            do_op(4'd8, 4'd9, t[i][0][3:0], 0, 0);
            got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL alu_op%h got=%h exp=%h", t[i][0][3:0], got, exp_v);
            end
        end
    endtask

    task automatic test_imm();
        load_rf(4'd1, 32'd10);
        sb_q.push_back(32'd15);
        do_op(4'd1, 4'd0, 4'h0, 1, 32'd5);
        got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL imm_add got=%h exp=%h", got, exp_v); end
        checks++;
        if ({oJ_zero, oJ_nZero, oJ_pos, oJ_neg} !== 4'b0110) begin
            errors++; $display("FAIL br_flags got=%b exp=0110", {oJ_zero, oJ_nZero, oJ_pos, oJ_neg});
        end
        sb_q.push_back(32'hFFFF_FFFB);
        do_op(4'd1, 4'd0, 4'h1, 1, 32'd15);
        got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL imm_sub got=%h exp=%h", got, exp_v); end
        checks++;
        if (oALU_neg !== 1'b1) begin errors++; $display("FAIL imm_neg got=%b exp=1", oALU_neg); end
    endtask

    task automatic test_pc();
        iPC_nRst = 0; iPC_en = 1; tick();
        for (int i = 0; i < 3; i++) begin iPC_en = 1; tick(); end
        sb_q.push_back(32'd3);
        iMUX_MAP = 1; #1; got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL pc_inc got=%h exp=%h", got, exp_v); end
        sb_q.push_back(32'd2);
        iPC_en = 1; iPC_jmp = 1; iPC_loadImm = 1; iImm32 = 32'hFFFF_FFFE; tick();
        iMUX_MAP = 1; #1; got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL pc_rel got=%h exp=%h", got, exp_v); end
        // Hold with en low, then capture PC through RWB (WBP) into R6.
        sb_q.push_back(32'd2);
        iPC_jmp = 1; iPC_loadImm = 1; iImm32 = 32'h40; tick();
        iMUX_WBP = 1; iRWB_en = 1; tick();
        iRF_Write = 1; iRF_AddrC = 4'd6; tick();
        read_rf(4'd6, got); exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL pc_wbp got=%h exp=%h", got, exp_v); end
        // Memory wins over PC in the write-back mux.
        sb_q.push_back(32'h5555_AAAA);
        iMemData = 32'h5555_AAAA; iMUX_WBM = 1; iMUX_WBP = 1; iRWB_en = 1; tick();
        iRF_Write = 1; iRF_AddrC = 4'd6; tick();
        read_rf(4'd6, got); exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL wb_prio got=%h exp=%h", got, exp_v); end
        // loadRA beats jmp+loadImm.
        load_rf(4'd10, 32'h0000_0100);
        iRF_AddrA = 4'd10; iRA_en = 1; tick();
        sb_q.push_back(32'h0000_0100);
        iPC_en = 1; iPC_loadRA = 1; iPC_jmp = 1; iPC_loadImm = 1; iImm32 = 32'h8; tick();
        iMUX_MAP = 1; #1; got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL pc_ra got=%h exp=%h", got, exp_v); end
        // Sync clear overrides en.
        sb_q.push_back(32'h0);
        iPC_nRst = 0; iPC_en = 1; tick();
        iMUX_MAP = 1; #1; got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL pc_clr got=%h exp=%h", got, exp_v); end
        // Wrap at 2^32.
        load_rf(4'd10, 32'hFFFF_FFFF);
        iRF_AddrA = 4'd10; iRA_en = 1; tick();
        iPC_en = 1; iPC_loadRA = 1; tick();
        sb_q.push_back(32'h0);
        iPC_en = 1; tick();
        iMUX_MAP = 1; #1; got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL pc_wrap got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_reset_mid();
        load_rf(4'd12, 32'hDEAD_BEEF);
        iRF_AddrA = 4'd12; iRA_en = 1; tick();
        for (int i = 0; i < 2; i++) begin iPC_en = 1; tick(); end
        #2; nRst = 0; #1;
        sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        read_rf(4'd12, got); exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL mid_rf got=%h exp=%h", got, exp_v); end
        iMUX_MAP = 1; #1; got = oMemAddr; exp_v = sb_q.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL mid_pc got=%h exp=%h", got, exp_v); end
        checks++;
        if (oJ_zero !== 1'b1 || oJ_nZero !== 1'b0) begin
            errors++; $display("FAIL mid_flags zero=%b nzero=%b exp=1 0", oJ_zero, oJ_nZero);
        end
        @(negedge iClk); nRst = 1;
    endtask

    initial begin
        idle();
        test_reset();
        test_load();
        test_sra();
        test_muldiv();
        test_alu_ops();
        test_imm();
        test_pc();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
